// File: rtl/wm8731_cfg_seq.sv
`timescale 1ns/1ps
// WM8731 configuration sequencer: after a power-up delay, writes the fixed 11-entry register table through codec_top's I2C master, then serves runtime req/ack writes.
// The first wr_i2c comes STARTUP_DELAY+1 cycles after reset release; each write waits for i2c_idle, and upd_req is held off until READY.
module wm8731_cfg_seq #(
  parameter logic [7:0] DEV_ADDR      = 8'h34,
  parameter int         STARTUP_DELAY = 50000,
  parameter int         GAP_CYCLES    = 64,
  parameter int         TIMEOUT       = 200000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i2c_idle,
  output logic        wr_i2c,
  output logic [23:0] i2c_packet,
  input  logic        upd_req,
  input  logic [6:0]  upd_addr,
  input  logic [8:0]  upd_data,
  output logic        upd_ack,
  output logic        init_done,
  output logic        init_error,
  output logic        busy,
  output logic [3:0]  step
);

  localparam int MAX_A   = (STARTUP_DELAY > GAP_CYCLES) ? STARTUP_DELAY : GAP_CYCLES;
  localparam int MAX_CNT = (MAX_A > TIMEOUT) ? MAX_A : TIMEOUT;
  localparam int CW      = $clog2(MAX_CNT + 1);

  localparam logic [CW-1:0] STARTUP_LAST = CW'(STARTUP_DELAY - 1);
  localparam logic [CW-1:0] GAP_LAST     = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT - 1);
  localparam logic [3:0]    LAST_STEP    = 4'd10;

  localparam logic [2:0] S_STARTUP   = 3'd0;
  localparam logic [2:0] S_ISSUE     = 3'd1;
  localparam logic [2:0] S_WAIT_BUSY = 3'd2;
  localparam logic [2:0] S_WAIT_DONE = 3'd3;
  localparam logic [2:0] S_GAP       = 3'd4;
  localparam logic [2:0] S_READY     = 3'd5;
  localparam logic [2:0] S_ERROR     = 3'd6;

  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic          upd_mode;
  logic [15:0]   upd_src;
  logic [15:0]   pkt_src;

  // {reg_addr[6:0], reg_data[8:0]} for each init table entry
  function automatic logic [15:0] table_entry(input logic [3:0] idx);
    logic [15:0] e;
    case (idx)
      4'd0:    e = {7'h0F, 9'h000};
      4'd1:    e = {7'h06, 9'h000};
      4'd2:    e = {7'h00, 9'h017};
      4'd3:    e = {7'h01, 9'h017};
      4'd4:    e = {7'h02, 9'h079};
      4'd5:    e = {7'h03, 9'h079};
      4'd6:    e = {7'h04, 9'h012};
      4'd7:    e = {7'h05, 9'h000};
      4'd8:    e = {7'h07, 9'h00A};
      4'd9:    e = {7'h08, 9'h000};
      4'd10:   e = {7'h09, 9'h001};
      default: e = 16'h0000;
    endcase
    return e;
  endfunction

  assign pkt_src = upd_mode ? upd_src : table_entry(step);
  assign busy    = (state != S_READY) && (state != S_ERROR);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= S_STARTUP;
      cnt        <= '0;
      step       <= '0;
      upd_mode   <= 1'b0;
      upd_src    <= '0;
      wr_i2c     <= 1'b0;
      i2c_packet <= '0;
      upd_ack    <= 1'b0;
      init_done  <= 1'b0;
      init_error <= 1'b0;
    end else begin
      wr_i2c  <= 1'b0;
      upd_ack <= 1'b0;
      case (state)
        S_STARTUP: begin
          if (cnt == STARTUP_LAST) begin
            cnt   <= '0;
            state <= S_ISSUE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_ISSUE: begin
          // No timeout here: a busy master is waited out indefinitely.
          if (i2c_idle) begin
            i2c_packet <= {DEV_ADDR, pkt_src};
            wr_i2c     <= 1'b1;
            cnt        <= '0;
            state      <= S_WAIT_BUSY;
          end
        end
        S_WAIT_BUSY: begin
          if (!i2c_idle) begin
            cnt   <= '0;
            state <= S_WAIT_DONE;
          end else if (cnt == TIMEOUT_LAST) begin
            init_error <= 1'b1;
            state      <= S_ERROR;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_WAIT_DONE: begin
          if (i2c_idle) begin
            cnt   <= '0;
            state <= S_GAP;
          end else if (cnt == TIMEOUT_LAST) begin
            init_error <= 1'b1;
            state      <= S_ERROR;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_GAP: begin
          if (cnt == GAP_LAST) begin
            cnt <= '0;
            if (upd_mode) begin
              upd_ack <= 1'b1;
              state   <= S_READY;
            end else if (step == LAST_STEP) begin
              init_done <= 1'b1;
              state     <= S_READY;
            end else begin
              step  <= step + 4'd1;
              state <= S_ISSUE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_READY: begin
          if (upd_req) begin
            upd_src  <= {upd_addr, upd_data};
            upd_mode <= 1'b1;
            state    <= S_ISSUE;
          end
        end
        S_ERROR: begin
          init_error <= 1'b1;
        end
        default: begin
          state <= S_STARTUP;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
